// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, data-memory freeze.
// Latency: control outputs are same-cycle combinational from registered state plus inputs.
// Backpressure: dmem_busy freezes the whole pipeline and parks the FSM in MEMWAIT until ready.
module pipeline_hazard_ctrl #(
  parameter int BRANCH_PENALTY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic [4:0]  ex_rd,
  input  logic        ex_readdmem,
  input  logic        ex_pcsrc,
  input  logic        dmem_busy,
  input  logic        clr_stats,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        flush,
  output logic        freeze,
  output logic [1:0]  hz_state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    FLUSH   = 2'b01,
    MEMWAIT = 2'b10
  } state_t;

  localparam logic [2:0] PEN_LOAD = 3'(BRANCH_PENALTY - 1);

  state_t     state, saved_state, eff_state;
  state_t     state_nxt, saved_state_nxt;
  logic [2:0] pen_cnt, saved_cnt, eff_cnt;
  logic [2:0] pen_cnt_nxt, saved_cnt_nxt;
  logic       load_use;
  logic       lu_stall;

  assign hz_state = state;

  // Load-use: EX holds a load whose destination is a source of the ID instruction
  assign load_use = ex_readdmem && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  // While frozen, behave as the state that was interrupted, so leaving MEMWAIT costs no cycle
  always_comb begin
    eff_state = state;
    eff_cnt   = pen_cnt;
    if (state == MEMWAIT) begin
      eff_state = saved_state;
      eff_cnt   = saved_cnt;
    end
  end

  // Output decode and next-state selection in priority order: rst, busy, branch, load-use
  always_comb begin
    pc_write        = 1'b1;
    ifid_write      = 1'b1;
    ifid_flush      = 1'b0;
    flush           = 1'b0;
    freeze          = 1'b0;
    lu_stall        = 1'b0;
    state_nxt       = RUN;
    pen_cnt_nxt     = 3'd0;
    saved_state_nxt = saved_state;
    saved_cnt_nxt   = saved_cnt;
    if (rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      flush      = 1'b1;
    end else if (dmem_busy) begin
      pc_write        = 1'b0;
      ifid_write      = 1'b0;
      freeze          = 1'b1;
      state_nxt       = MEMWAIT;
      pen_cnt_nxt     = pen_cnt;
      saved_state_nxt = eff_state;
      saved_cnt_nxt   = eff_cnt;
    end else if (eff_state == FLUSH) begin
      ifid_flush = 1'b1;
      flush      = 1'b1;
      if (eff_cnt > 3'd1) begin
        state_nxt   = FLUSH;
        pen_cnt_nxt = eff_cnt - 3'd1;
      end
    end else if (ex_pcsrc) begin
      ifid_flush  = 1'b1;
      flush       = 1'b1;
      pen_cnt_nxt = PEN_LOAD;
      state_nxt   = (PEN_LOAD != 3'd0) ? FLUSH : RUN;
    end else if (load_use) begin
      // Bubble replaces the load in EX next cycle, so the hazard clears after one stall
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      flush      = 1'b1;
      lu_stall   = 1'b1;
    end
  end

  // FSM state, saved context and penalty counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      saved_state <= RUN;
      pen_cnt     <= 3'd0;
      saved_cnt   <= 3'd0;
    end else begin
      state       <= state_nxt;
      saved_state <= saved_state_nxt;
      pen_cnt     <= pen_cnt_nxt;
      saved_cnt   <= saved_cnt_nxt;
    end
  end

  // Saturating statistics; clr_stats wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if ((lu_stall || freeze) && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if (ifid_flush && (flush_cnt != 16'hFFFF))
        flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with BRANCH_PENALTY=2.
// Output vector order: {pc_write, ifid_write, ifid_flush, flush, freeze}.
// Inputs change 1ns after a rising edge; outputs are sampled mid-cycle and 1ns after edges.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_uses_rt, ex_readdmem, ex_pcsrc, dmem_busy, clr_stats;
  logic        pc_write, ifid_write, ifid_flush, flush, freeze;
  logic [1:0]  hz_state;
  logic [15:0] stall_cnt, flush_cnt;
  logic [4:0]  outs;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [4:0] O_IDLE  = 5'b11000;
  localparam logic [4:0] O_LU    = 5'b00010;
  localparam logic [4:0] O_BR    = 5'b11110;
  localparam logic [4:0] O_FRZ   = 5'b00001;
  localparam logic [4:0] O_RST   = 5'b00110;

  pipeline_hazard_ctrl #(.BRANCH_PENALTY(2)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .ex_readdmem(ex_readdmem), .ex_pcsrc(ex_pcsrc),
    .dmem_busy(dmem_busy), .clr_stats(clr_stats),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .flush(flush), .freeze(freeze), .hz_state(hz_state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign outs = {pc_write, ifid_write, ifid_flush, flush, freeze};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic [4:0] rd, input logic rdm, input logic pc,
                       input logic busy);
    id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_rd = rd;
    ex_readdmem = rdm; ex_pcsrc = pc; dmem_busy = busy;
    #1;
  endtask

  initial begin
    rst = 1'b1; clr_stats = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_outs", 32'(outs), 32'(O_RST));
    // rst overrides busy and branch on the outputs
    drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1);
    chk("rst_outs_ovr", 32'(outs), 32'(O_RST));
    tick();
    chk("rst_state", 32'(hz_state), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_flushc", 32'(flush_cnt), 32'd0);

    rst = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("idle_outs", 32'(outs), 32'(O_IDLE));
    tick();
    chk("idle_stall", 32'(stall_cnt), 32'd0);

    // load-use on rs
    drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("lu_rs_outs", 32'(outs), 32'(O_LU));
    tick();
    chk("lu_rs_stall", 32'(stall_cnt), 32'd1);
    chk("lu_rs_state", 32'(hz_state), 32'd0);
    // r0 destination never hazards
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("lu_r0_outs", 32'(outs), 32'(O_IDLE));
    tick();
    chk("lu_r0_stall", 32'(stall_cnt), 32'd1);
    // load-use on rt, only when rt is read
    drive(5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    chk("lu_rt_outs", 32'(outs), 32'(O_LU));
    tick();
    chk("lu_rt_stall", 32'(stall_cnt), 32'd2);
    drive(5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    chk("lu_rt_unused", 32'(outs), 32'(O_IDLE));
    tick();
    chk("lu_rt_unused_stall", 32'(stall_cnt), 32'd2);

    // taken branch, penalty 2
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("br_t0_outs", 32'(outs), 32'(O_BR));
    tick();
    chk("br_t1_state", 32'(hz_state), 32'd1);
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("br_t1_outs", 32'(outs), 32'(O_BR));
    tick();
    chk("br_t2_state", 32'(hz_state), 32'd0);
    chk("br_flushc", 32'(flush_cnt), 32'd2);
    chk("br_t2_outs", 32'(outs), 32'(O_IDLE));
    tick();

    // branch interrupted by 3 busy cycles at T+1
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("brb_t0_outs", 32'(outs), 32'(O_BR));
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      chk("brb_busy_outs", 32'(outs), 32'(O_FRZ));
      tick();
      chk("brb_busy_state", 32'(hz_state), 32'd2);
    end
    chk("brb_stall", 32'(stall_cnt), 32'd5);
    chk("brb_flushc_hold", 32'(flush_cnt), 32'd3);
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("brb_resume_outs", 32'(outs), 32'(O_BR));
    tick();
    chk("brb_end_state", 32'(hz_state), 32'd0);
    chk("brb_flushc", 32'(flush_cnt), 32'd4);
    chk("brb_end_outs", 32'(outs), 32'(O_IDLE));
    tick();

    // branch beats load-use, and load-use is ignored during FLUSH
    drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    chk("brlu_outs", 32'(outs), 32'(O_BR));
    tick();
    chk("brlu_stall", 32'(stall_cnt), 32'd5);
    chk("brlu_state", 32'(hz_state), 32'd1);
    drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("brlu_fl_outs", 32'(outs), 32'(O_BR));
    tick();
    chk("brlu_fl_stall", 32'(stall_cnt), 32'd5);
    chk("brlu_fl_flushc", 32'(flush_cnt), 32'd6);
    chk("brlu_fl_state", 32'(hz_state), 32'd0);

    // load-use hidden under busy is re-evaluated after busy
    drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1);
    chk("lub_busy_outs", 32'(outs), 32'(O_FRZ));
    tick();
    chk("lub_state", 32'(hz_state), 32'd2);
    drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("lub_resume_outs", 32'(outs), 32'(O_LU));
    tick();
    chk("lub_stall", 32'(stall_cnt), 32'd7);
    chk("lub_end_state", 32'(hz_state), 32'd0);

    // reset during MEMWAIT
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("rmw_state", 32'(hz_state), 32'd2);
    rst = 1'b1;
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("rmw_outs", 32'(outs), 32'(O_RST));
    tick();
    chk("rmw_state_after", 32'(hz_state), 32'd0);
    chk("rmw_stall", 32'(stall_cnt), 32'd0);
    chk("rmw_flushc", 32'(flush_cnt), 32'd0);
    rst = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("rmw_release_outs", 32'(outs), 32'(O_IDLE));
    tick();

    // stall counter saturation via sustained busy, then clear with concurrent stall
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 65540; i++) tick();
    chk("sat_stall", 32'(stall_cnt), 32'hFFFF);
    tick();
    chk("sat_stall_hold", 32'(stall_cnt), 32'hFFFF);
    clr_stats = 1'b1;
    tick();
    chk("clr_stall", 32'(stall_cnt), 32'd0);
    chk("clr_flushc", 32'(flush_cnt), 32'd0);
    clr_stats = 1'b0;
    tick();
    chk("post_clr_stall", 32'(stall_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter BRANCH_PENALTY, default 2, legal 1..7: total cycles flush is asserted per taken branch.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 id_rs  in  5  source register 1 of the instruction in ID.
REQ-005 id_rt  in  5  source register 2 of the instruction in ID.
REQ-006 id_uses_rt  in  1  ID instruction reads id_rt.
REQ-007 ex_rd  in  5  destination register of the instruction in EX.
REQ-008 ex_readdmem  in  1  EX instruction is a load.
REQ-009 ex_pcsrc  in  1  branch resolved taken in EX.
REQ-010 dmem_busy  in  1  data memory not ready; whole pipeline must hold.
REQ-011 clr_stats  in  1  synchronous clear of the statistics counters.
REQ-012 pc_write  out  1  PC load enable.
REQ-013 ifid_write  out  1  IF/ID register load enable.
REQ-014 ifid_flush  out  1  squash the IF/ID instruction (load a NOP).
REQ-015 flush  out  1  drives the ID-stage control-zeroing flush input (bubble into ID/EX).
REQ-016 freeze  out  1  hold ID/EX, EX/MEM and MEM/WB registers.
REQ-017 hz_state  out  2  registered FSM state: RUN=00, FLUSH=01, MEMWAIT=10.
REQ-018 stall_cnt  out  16  saturating count of stall cycles.
REQ-019 flush_cnt  out  16  saturating count of branch-flush cycles.

Function
REQ-020 Outputs pc_write, ifid_write, ifid_flush, flush and freeze SHALL be combinational from the registered state and the current inputs (same-cycle response, zero latency).
REQ-021 Event priority in any cycle: rst > dmem_busy > taken branch > load-use.
REQ-022 Idle (RUN, no event): pc_write=1, ifid_write=1, ifid_flush=0, flush=0, freeze=0.
REQ-023 Load-use hazard = ex_readdmem & (ex_rd!=0) & ((ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)); only evaluated in RUN.
REQ-024 Load-use response: pc_write=0, ifid_write=0, flush=1, ifid_flush=0, freeze=0; state stays RUN; exactly one bubble per hazard because the bubble clears the EX-stage load.
REQ-025 Taken branch in RUN: flush=1, ifid_flush=1, pc_write=1, ifid_write=1, freeze=0; penalty counter loads BRANCH_PENALTY-1; next state FLUSH if that value >0, else RUN.
REQ-026 FLUSH state: same outputs as REQ-025; counter decrements each cycle; transition to RUN on the edge where counter is 1; ex_pcsrc and load-use ignored.
REQ-027 dmem_busy=1 in any state: freeze=1, pc_write=0, ifid_write=0, flush=0, ifid_flush=0; next state MEMWAIT; the pre-freeze state and penalty counter are saved and held unchanged.
REQ-028 MEMWAIT with dmem_busy=0: outputs and transition are those of the saved state evaluated with current inputs, in that same cycle (no extra bubble).
REQ-029 Branch or load-use coincident with dmem_busy is not lost: EX is frozen, so the condition is re-evaluated on the first non-busy cycle.
REQ-030 stall_cnt increments in every cycle with a load-use stall or freeze=1; flush_cnt increments in every cycle with ifid_flush=1 while rst=0; both saturate at 0xFFFF.
REQ-031 clr_stats=1 zeroes both counters at the next edge, overriding any increment that cycle.

Reset
REQ-032 At a rising edge with rst=1: state=RUN, saved state=RUN, penalty counter=0, stall_cnt=0, flush_cnt=0.
REQ-033 While rst=1: pc_write=0, ifid_write=0, flush=1, ifid_flush=1, freeze=0, independent of other inputs; no counter increments.
REQ-034 rst asserted mid-FLUSH or mid-MEMWAIT abandons the sequence; first cycle after rst release behaves as RUN.

Verification
REQ-035 Load-use: ex_readdmem=1, ex_rd=5, id_rs=5 for one cycle -> pc_write=0, ifid_write=0, flush=1 that cycle, stall_cnt +1; ex_rd=0 same inputs -> no stall.
REQ-036 Branch, BRANCH_PENALTY=2: ex_pcsrc=1 at cycle T -> flush=ifid_flush=1 at T and T+1, hz_state=01 at T+1, RUN at T+2, flush_cnt=2.
REQ-037 dmem_busy=1 at T+1 of a branch flush for 3 cycles -> freeze=1, flush=0 for 3 cycles, hz_state=10; then one remaining flush cycle, then RUN.
REQ-038 Simultaneous ex_pcsrc=1 and load-use -> branch response only (pc_write=1, ifid_flush=1), stall_cnt unchanged.
REQ-039 Counters preset near 0xFFFF by sustained dmem_busy -> stall_cnt holds 0xFFFF; clr_stats=1 with a concurrent stall -> 0 next cycle.
REQ-040 rst=1 during MEMWAIT with dmem_busy=1 -> REQ-033 outputs, hz_state=00 after edge, counters 0.
